clk_en_gen: RTL and testbench



---
 rtl/clk_en_gen.sv | 132 +++++++++++++
 tb/tb_clk_en_gen.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_en_gen.sv
// clk_en_gen: multi-channel clock-enable generator.
// Every channel divides CLK100MHz by a runtime-programmable divisor and emits
// a one-cycle enable pulse plus a 50% square wave. A new divisor is parked
// until the current period completes (glitch-free), loads at once on an idle
// channel, and SYNC restarts every channel phase-aligned.
`timescale 1ns/1ps

// One divider channel: counter, active/pending divisor and registered outputs.
module clk_en_ch #(
    parameter int              CNT_W   = 17,
    parameter logic [CNT_W-1:0] DIV_RST = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic [CNT_W-1:0] din,
    input  logic             sync,
    output logic             en,
    output logic             sqw,
    output logic             pend
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] pdiv;
    logic [CNT_W-1:0] div_nxt;
    logic             pv;
    logic             active;
    logic             tc;
    logic             load;

    // A zero divisor parks the channel; DIV-1 cannot underflow while active.
    assign active = (div != '0);
    assign tc     = active && (cnt == div - CNT_W'(1));

    // Pending divisors take effect at period end, when idle, or on SYNC.
    assign load   = sync || !active || tc;

    assign pend   = pv;

    // Divisor that becomes active on a load edge: a same-edge write wins.
    always_comb begin
        div_nxt = div;
        if (wr)
            div_nxt = din;
        else if (pv)
            div_nxt = pdiv;
    end

    // Divisor bookkeeping: park writes in PDIV, promote them on a load edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div  <= DIV_RST;
            pdiv <= '0;
            pv   <= 1'b0;
        end else if (load) begin
            div  <= div_nxt;
            pv   <= 1'b0;
        end else if (wr) begin
            pdiv <= din;
            pv   <= 1'b1;
        end
    end

    // Counter and registered enable / square-wave outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            en  <= 1'b0;
            sqw <= 1'b0;
        end else if (sync || !active) begin
            cnt <= '0;
            en  <= 1'b0;
            sqw <= 1'b0;
        end else if (tc) begin
            cnt <= '0;
            // Loading a zero divisor at period end shuts the channel off now.
            if (div_nxt == '0) begin
                en  <= 1'b0;
                sqw <= 1'b0;
            end else begin
                en  <= 1'b1;
                sqw <= ~sqw;
            end
        end else begin
            cnt <= cnt + CNT_W'(1);
            en  <= 1'b0;
        end
    end

endmodule

// Top level: write decode and one divider instance per channel.
module clk_en_gen #(
    parameter int                      NUM_CH   = 3,
    parameter int                      CNT_W    = 17,
    parameter int                      SEL_W    = 2,
    parameter logic [NUM_CH*CNT_W-1:0] DIV_INIT = {17'd65536, 17'd1024, 17'd50000}
) (
    input  logic              CLK100MHz,
    input  logic              RESETn,
    input  logic [CNT_W-1:0]  DIV_IN,
    input  logic [SEL_W-1:0]  DIV_SEL,
    input  logic              DIV_WE,
    input  logic              SYNC,
    output logic [NUM_CH-1:0] EN_OUT,
    output logic [NUM_CH-1:0] SQW_OUT,
    output logic [NUM_CH-1:0] PEND_OUT
);

    // Out-of-range DIV_SEL matches no channel, so such writes are dropped.
    logic [NUM_CH-1:0] wr;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign wr[i] = DIV_WE && (DIV_SEL == SEL_W'(i));

        clk_en_ch #(
            .CNT_W   (CNT_W),
            .DIV_RST (DIV_INIT[i*CNT_W +: CNT_W])
        ) u_ch (
            .clk   (CLK100MHz),
            .rst_n (RESETn),
            .wr    (wr[i]),
            .din   (DIV_IN),
            .sync  (SYNC),
            .en    (EN_OUT[i]),
            .sqw   (SQW_OUT[i]),
            .pend  (PEND_OUT[i])
        );
    end

endmodule

// File: tb/tb_clk_en_gen.sv
// tb_clk_en_gen: directed checks of clk_en_gen with default parameters.
// Long default-divisor runs and reprogramming use hand-written sequences;
// the short-divisor corner cases use a per-cycle vector table.
`timescale 1ns/1ps

module tb_clk_en_gen;

    logic        CLK100MHz = 1'b0;
    logic        RESETn    = 1'b0;
    logic [16:0] DIV_IN    = '0;
    logic [1:0]  DIV_SEL   = '0;
    logic        DIV_WE    = 1'b0;
    logic        SYNC      = 1'b0;
    logic [2:0]  EN_OUT;
    logic [2:0]  SQW_OUT;
    logic [2:0]  PEND_OUT;

    int checks = 0;
    int errors = 0;

    clk_en_gen dut (
        .CLK100MHz (CLK100MHz),
        .RESETn    (RESETn),
        .DIV_IN    (DIV_IN),
        .DIV_SEL   (DIV_SEL),
        .DIV_WE    (DIV_WE),
        .SYNC      (SYNC),
        .EN_OUT    (EN_OUT),
        .SQW_OUT   (SQW_OUT),
        .PEND_OUT  (PEND_OUT)
    );

    always #5 CLK100MHz = ~CLK100MHz;

    typedef struct {
        logic        we;
        logic [1:0]  sel;
        logic [16:0] din;
        logic        sync;
        logic [2:0]  en;
        logic [2:0]  sqw;
        logic [2:0]  pend;
    } vec_t;

    vec_t vecs[31];

    function automatic vec_t mk(input logic we, input logic [1:0] sel, input logic [16:0] din,
                                input logic sync, input logic [2:0] en, input logic [2:0] sqw,
                                input logic [2:0] pend);
        vec_t v;
        v.we = we; v.sel = sel; v.din = din; v.sync = sync;
        v.en = en; v.sqw = sqw; v.pend = pend;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive inputs for one edge, then sample 1ns after that edge.
    task automatic step(input logic we, input logic [1:0] sel, input logic [16:0] din,
                        input logic sync);
        DIV_WE = we; DIV_SEL = sel; DIV_IN = din; SYNC = sync;
        @(posedge CLK100MHz);
        #1;
        DIV_WE = 1'b0; SYNC = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int bad_a, bad_b, bad_c, first0, first2, cnt0, cnt2, steps;

    initial begin
        // k: {we, sel, din, sync} -> {en, sqw, pend} after that edge
        vecs[0]  = mk(1, 0, 6, 1, 3'b000, 3'b000, 3'b000);
        vecs[1]  = mk(0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
        vecs[2]  = mk(0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
        vecs[3]  = mk(0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
        vecs[4]  = mk(0, 0, 0, 0, 3'b010, 3'b010, 3'b000);
        vecs[5]  = mk(0, 0, 0, 0, 3'b000, 3'b010, 3'b000);
        vecs[6]  = mk(0, 0, 0, 0, 3'b001, 3'b011, 3'b000);
        vecs[7]  = mk(0, 0, 0, 0, 3'b000, 3'b011, 3'b000);
        vecs[8]  = mk(1, 0, 0, 0, 3'b010, 3'b001, 3'b001);
        vecs[9]  = mk(0, 0, 0, 0, 3'b000, 3'b001, 3'b001);
        vecs[10] = mk(0, 0, 0, 0, 3'b000, 3'b001, 3'b001);
        vecs[11] = mk(0, 0, 0, 0, 3'b000, 3'b001, 3'b001);
        vecs[12] = mk(0, 0, 0, 0, 3'b010, 3'b010, 3'b000);
        vecs[13] = mk(1, 3, 5, 0, 3'b000, 3'b010, 3'b000);
        vecs[14] = mk(0, 0, 0, 0, 3'b000, 3'b010, 3'b000);
        vecs[15] = mk(0, 0, 0, 0, 3'b000, 3'b010, 3'b000);
        vecs[16] = mk(0, 0, 0, 0, 3'b010, 3'b000, 3'b000);
        vecs[17] = mk(1, 0, 3, 0, 3'b000, 3'b000, 3'b000);
        vecs[18] = mk(0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
        vecs[19] = mk(0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
        vecs[20] = mk(0, 0, 0, 0, 3'b011, 3'b011, 3'b000);
        vecs[21] = mk(0, 0, 0, 0, 3'b000, 3'b011, 3'b000);
        vecs[22] = mk(0, 0, 0, 0, 3'b000, 3'b011, 3'b000);
        vecs[23] = mk(0, 0, 0, 0, 3'b001, 3'b010, 3'b000);
        vecs[24] = mk(1, 1, 2, 0, 3'b010, 3'b000, 3'b000);
        vecs[25] = mk(0, 0, 0, 0, 3'b000, 3'b000, 3'b000);
        vecs[26] = mk(0, 0, 0, 0, 3'b011, 3'b011, 3'b000);
        vecs[27] = mk(0, 0, 0, 0, 3'b000, 3'b011, 3'b000);
        vecs[28] = mk(0, 0, 0, 0, 3'b010, 3'b001, 3'b000);
        vecs[29] = mk(0, 0, 0, 0, 3'b001, 3'b000, 3'b000);
        vecs[30] = mk(0, 0, 0, 0, 3'b010, 3'b010, 3'b000);

        // Reset state
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("rst_en", EN_OUT, 0);
        chk("rst_sqw", SQW_OUT, 0);
        chk("rst_pend", PEND_OUT, 0);

        // Default divisors from reset release; n = rising edges since release
        RESETn = 1'b1;
        bad_a = 0; bad_b = 0; bad_c = 0; first0 = 0; first2 = 0; cnt0 = 0; cnt2 = 0;
        for (int n = 1; n <= 65536; n++) begin
            step(0, 0, 0, 0);
            if (EN_OUT[1] !== (n % 1024 == 0)) bad_a++;
            if (SQW_OUT[1] !== ((n / 1024) % 2 == 1)) bad_b++;
            if (PEND_OUT !== 3'b000) bad_c++;
            if (EN_OUT[0] === 1'b1) begin cnt0++; if (first0 == 0) first0 = n; end
            if (EN_OUT[2] === 1'b1) begin cnt2++; if (first2 == 0) first2 = n; end
        end
        chk("def_en1_period1024", bad_a, 0);
        chk("def_sqw1_period2048", bad_b, 0);
        chk("def_pend_zero", bad_c, 0);
        chk("def_en0_first", first0, 50000);
        chk("def_en0_count", cnt0, 1);
        chk("def_en2_first", first2, 65536);
        chk("def_en2_count", cnt2, 1);

        // Glitch-free reprogram: write 4 to ch1 while its count is at 100
        for (int n = 0; n < 100; n++) step(0, 0, 0, 0);
        step(1, 1, 4, 0);
        chk("reprog_pend1_set", PEND_OUT, 3'b010);
        chk("reprog_en1_low", EN_OUT[1], 0);
        steps = 0; bad_a = 0;
        while (EN_OUT[1] !== 1'b1 && steps < 2000) begin
            step(0, 0, 0, 0);
            steps++;
            if (EN_OUT[1] !== 1'b1 && PEND_OUT[1] !== 1'b1) bad_a++;
        end
        chk("reprog_old_boundary", steps, 923);
        chk("reprog_pend_held", bad_a, 0);
        chk("reprog_pend1_clear", PEND_OUT[1], 0);
        bad_a = 0;
        for (int j = 1; j <= 8; j++) begin
            step(0, 0, 0, 0);
            if (EN_OUT[1] !== (j % 4 == 0)) bad_a++;
        end
        chk("reprog_en1_period4", bad_a, 0);

        // SYNC+write, disable at terminal count, re-enable, bad select, write at TC
        foreach (vecs[i]) begin
            step(vecs[i].we, vecs[i].sel, vecs[i].din, vecs[i].sync);
            chk($sformatf("vec%0d_en", i), EN_OUT, vecs[i].en);
            chk($sformatf("vec%0d_sqw", i), SQW_OUT, vecs[i].sqw);
            chk($sformatf("vec%0d_pend", i), PEND_OUT, vecs[i].pend);
        end

        // SYNC alignment: ch2 pending 8, ch1 written 8 on the SYNC edge
        step(1, 2, 8, 0);
        chk("sync_pend2_set", PEND_OUT, 3'b100);
        step(1, 1, 8, 1);
        chk("sync_pend_clear", PEND_OUT, 0);
        chk("sync_en_clear", EN_OUT, 0);
        chk("sync_sqw_clear", SQW_OUT, 0);
        bad_a = 0; bad_b = 0; bad_c = 0;
        for (int j = 1; j <= 24; j++) begin
            step(0, 0, 0, 0);
            if (EN_OUT[1] !== EN_OUT[2] || SQW_OUT[1] !== SQW_OUT[2]) bad_a++;
            if (EN_OUT[1] !== (j % 8 == 0)) bad_b++;
            if (SQW_OUT[1] !== ((j / 8) % 2 == 1)) bad_c++;
        end
        chk("sync_ch1_ch2_equal", bad_a, 0);
        chk("sync_en1_period8", bad_b, 0);
        chk("sync_sqw1_period16", bad_c, 0);

        // Divisor 1: enable every cycle, square wave toggles every cycle
        step(1, 0, 1, 1);
        chk("div1_en0_sync", EN_OUT[0], 0);
        bad_a = 0;
        for (int j = 1; j <= 6; j++) begin
            step(0, 0, 0, 0);
            if (EN_OUT[0] !== 1'b1) bad_a++;
            if (SQW_OUT[0] !== (j % 2 == 1)) bad_a++;
        end
        chk("div1_en_sqw", bad_a, 0);

        // Asynchronous reset with a pending write outstanding
        step(1, 2, 5, 0);
        chk("arst_pend2_set", PEND_OUT, 3'b100);
        #3;
        RESETn = 1'b0;
        #1;
        chk("arst_en_now", EN_OUT, 0);
        chk("arst_sqw_now", SQW_OUT, 0);
        chk("arst_pend_now", PEND_OUT, 0);
        @(posedge CLK100MHz);
        #1;
        RESETn = 1'b1;
        bad_a = 0; bad_b = 0;
        for (int n = 1; n <= 1024; n++) begin
            step(0, 0, 0, 0);
            if (EN_OUT[1] !== (n == 1024)) bad_a++;
            if (EN_OUT[0] !== 1'b0 || EN_OUT[2] !== 1'b0 || PEND_OUT !== 3'b000) bad_b++;
        end
        chk("arst_en1_default", bad_a, 0);
        chk("arst_write_lost", bad_b, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
